// File: rtl/vanilla_remote_load_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_remote_load_wb_sched
// Summary  : Buffers returned remote load responses in two independent FIFOs
//            (int RF and float RF). Each FIFO presents its head as a writeback
//            request. A per-channel stall counter raises a force flag once a
//            head has waited stall_threshold_p cycles without being consumed.
// Revision : 1.0 - initial release
// ============================================================================
module vanilla_remote_load_wb_sched #(
    parameter int data_width_p      = 32,
    parameter int reg_addr_width_p  = 5,
    parameter int fifo_els_p        = 2,
    parameter int stall_threshold_p = 15
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        in_v_i,
    input  logic                        in_float_i,
    input  logic [reg_addr_width_p-1:0] in_rd_i,
    input  logic [data_width_p-1:0]     in_data_i,
    output logic                        in_ready_o,

    output logic                        int_v_o,
    output logic [reg_addr_width_p-1:0] int_rd_o,
    output logic [data_width_p-1:0]     int_data_o,
    output logic                        int_force_o,
    input  logic                        int_yumi_i,

    output logic                        float_v_o,
    output logic [reg_addr_width_p-1:0] float_rd_o,
    output logic [data_width_p-1:0]     float_data_o,
    output logic                        float_force_o,
    input  logic                        float_yumi_i
);

    localparam int c_ptr_w   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int c_cnt_w   = $clog2(fifo_els_p + 1);
    localparam int c_stall_w = (stall_threshold_p > 0) ? $clog2(stall_threshold_p + 1) : 1;
    localparam int c_entry_w = reg_addr_width_p + data_width_p;

    localparam logic [c_ptr_w-1:0]   c_last_ptr  = c_ptr_w'(fifo_els_p - 1);
    localparam logic [c_cnt_w-1:0]   c_full_cnt  = c_cnt_w'(fifo_els_p);
    localparam logic [c_stall_w-1:0] c_stall_max = c_stall_w'(stall_threshold_p);

    // Channel index 0 is the int RF, channel index 1 is the float RF.
    logic                        w_full  [2];
    logic                        w_v     [2];
    logic                        w_force [2];
    logic                        w_yumi  [2];
    logic [reg_addr_width_p-1:0] w_rd    [2];
    logic [data_width_p-1:0]     w_data  [2];

    assign w_yumi[0] = int_yumi_i;
    assign w_yumi[1] = float_yumi_i;

    // Ready depends only on the FIFO the offered response targets.
    assign in_ready_o = in_float_i ? ~w_full[1] : ~w_full[0];

    assign int_v_o       = w_v[0];
    assign int_rd_o      = w_rd[0];
    assign int_data_o    = w_data[0];
    assign int_force_o   = w_force[0];
    assign float_v_o     = w_v[1];
    assign float_rd_o    = w_rd[1];
    assign float_data_o  = w_data[1];
    assign float_force_o = w_force[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [c_entry_w-1:0] r_mem [fifo_els_p];
        logic [c_ptr_w-1:0]   r_wr_ptr;
        logic [c_ptr_w-1:0]   r_rd_ptr;
        logic [c_cnt_w-1:0]   r_count;
        logic [c_stall_w-1:0] r_stall;
        logic                 w_sel;
        logic                 w_empty;
        logic                 w_enq;
        logic                 w_deq;

        assign w_sel    = (gi == 1) ? in_float_i : ~in_float_i;
        assign w_empty  = (r_count == '0);
        assign w_full[gi] = (r_count == c_full_cnt);
        // A full FIFO refuses input even if it is draining this cycle.
        assign w_enq    = in_v_i & w_sel & ~w_full[gi];
        // Yumi on an empty FIFO is ignored so the count cannot underflow.
        assign w_deq    = w_yumi[gi] & ~w_empty;

        // Pointer and occupancy bookkeeping; pointers wrap at fifo_els_p.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_deq) begin
                    r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Head wait counter: restarts on consume, idles at 0 when empty, saturates.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_stall <= '0;
            end else if (w_deq || w_empty) begin
                r_stall <= '0;
            end else if (r_stall != c_stall_max) begin
                r_stall <= r_stall + 1'b1;
            end
        end

        // Entry storage; contents are qualified by occupancy so no reset is needed.
        always_ff @(posedge clk_i) begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= {in_rd_i, in_data_i};
            end
        end

        assign w_v[gi]              = ~w_empty;
        assign {w_rd[gi], w_data[gi]} = r_mem[r_rd_ptr];
        assign w_force[gi]          = ~w_empty & (r_stall == c_stall_max);
    end

endmodule
`default_nettype wire

// File: tb/tb_vanilla_remote_load_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vanilla_remote_load_wb_sched
// Summary  : Directed self-checking bench for vanilla_remote_load_wb_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vanilla_remote_load_wb_sched;

    logic        clk;
    logic        reset_n;
    logic        in_v;
    logic        in_float;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_ready;
    logic        int_v;
    logic [4:0]  int_rd;
    logic [31:0] int_data;
    logic        int_force;
    logic        int_yumi;
    logic        float_v;
    logic [4:0]  float_rd;
    logic [31:0] float_data;
    logic        float_force;
    logic        float_yumi;

    int tests;
    int fails;

    vanilla_remote_load_wb_sched #(
        .data_width_p      (32),
        .reg_addr_width_p  (5),
        .fifo_els_p        (2),
        .stall_threshold_p (15)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .in_v_i        (in_v),
        .in_float_i    (in_float),
        .in_rd_i       (in_rd),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .int_v_o       (int_v),
        .int_rd_o      (int_rd),
        .int_data_o    (int_data),
        .int_force_o   (int_force),
        .int_yumi_i    (int_yumi),
        .float_v_o     (float_v),
        .float_rd_o    (float_rd),
        .float_data_o  (float_data),
        .float_force_o (float_force),
        .float_yumi_i  (float_yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_v       = 1'b0;
        in_float   = 1'b0;
        in_rd      = '0;
        in_data    = '0;
        int_yumi   = 1'b0;
        float_yumi = 1'b0;
    endtask

    task automatic offer(input logic fl, input logic [4:0] rd, input logic [31:0] data);
        in_v     = 1'b1;
        in_float = fl;
        in_rd    = rd;
        in_data  = data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #3;
        tests++; if (int_v !== 1'b0 || float_v !== 1'b0) begin
            fails++; $display("FAIL reset_v: int_v=%b float_v=%b expected 0 0", int_v, float_v); end
        tests++; if (int_force !== 1'b0 || float_force !== 1'b0) begin
            fails++; $display("FAIL reset_force: int=%b float=%b expected 0 0", int_force, float_force); end
        tests++; if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        // First enqueue lands on the first edge after release.
        offer(1'b0, 5'd1, 32'h0000_0001);
        tick();
        idle_inputs();
        tests++; if (int_v !== 1'b1 || int_rd !== 5'd1) begin
            fails++; $display("FAIL reset_first_enq: v=%b rd=%0d expected 1 1", int_v, int_rd); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
    endtask

    task automatic test_basic();
        offer(1'b0, 5'd3, 32'hDEAD_BEEF);
        #1;
        tests++; if (in_ready !== 1'b1 || int_v !== 1'b0) begin
            fails++; $display("FAIL basic_pre: ready=%b int_v=%b expected 1 0", in_ready, int_v); end
        tick();
        idle_inputs();
        tests++; if (int_v !== 1'b1 || int_rd !== 5'd3 || int_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL basic_head: v=%b rd=%0d data=%h expected 1 3 deadbeef", int_v, int_rd, int_data); end
        tests++; if (float_v !== 1'b0) begin
            fails++; $display("FAIL basic_float_idle: float_v=%b expected 0", float_v); end
        tick();
        tests++; if (int_v !== 1'b1 || int_data !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL basic_hold: v=%b data=%h expected 1 deadbeef", int_v, int_data); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
        tests++; if (int_v !== 1'b0) begin
            fails++; $display("FAIL basic_drain: int_v=%b expected 0", int_v); end
    endtask

    task automatic test_full();
        offer(1'b1, 5'd1, 32'h11);
        tick();
        offer(1'b1, 5'd2, 32'h22);
        tick();
        idle_inputs();
        in_float = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin
            fails++; $display("FAIL full_ready_float: got %b expected 0", in_ready); end
        in_float = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin
            fails++; $display("FAIL full_ready_int: got %b expected 1", in_ready); end
        tests++; if (float_v !== 1'b1 || float_rd !== 5'd1 || float_data !== 32'h11) begin
            fails++; $display("FAIL full_head: v=%b rd=%0d data=%h expected 1 1 11", float_v, float_rd, float_data); end
        // Third offer with a same-cycle consume must still be refused.
        offer(1'b1, 5'd7, 32'h77);
        float_yumi = 1'b1;
        tick();
        idle_inputs();
        tests++; if (float_v !== 1'b1 || float_rd !== 5'd2 || float_data !== 32'h22) begin
            fails++; $display("FAIL full_second: v=%b rd=%0d data=%h expected 1 2 22", float_v, float_rd, float_data); end
        float_yumi = 1'b1;
        tick();
        float_yumi = 1'b0;
        tests++; if (float_v !== 1'b0) begin
            fails++; $display("FAIL full_no_third: float_v=%b rd=%0d expected v=0", float_v, float_rd); end
    endtask

    task automatic test_force();
        offer(1'b0, 5'd5, 32'h55);
        tick();                     // head valid, wait count 0
        offer(1'b0, 5'd6, 32'h66);
        tick();                     // wait count 1
        idle_inputs();
        repeat (13) tick();         // wait count 14
        tests++; if (int_force !== 1'b0) begin
            fails++; $display("FAIL force_early: got %b expected 0 at 14 cycles", int_force); end
        tick();                     // wait count 15
        tests++; if (int_force !== 1'b1 || int_rd !== 5'd5) begin
            fails++; $display("FAIL force_set: force=%b rd=%0d expected 1 5", int_force, int_rd); end
        repeat (3) tick();
        tests++; if (int_force !== 1'b1) begin
            fails++; $display("FAIL force_sat: got %b expected 1", int_force); end
        tests++; if (float_force !== 1'b0) begin
            fails++; $display("FAIL force_float_idle: got %b expected 0", float_force); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
        tests++; if (int_force !== 1'b0 || int_v !== 1'b1 || int_rd !== 5'd6) begin
            fails++; $display("FAIL force_after_yumi: force=%b v=%b rd=%0d expected 0 1 6", int_force, int_v, int_rd); end
        repeat (14) tick();
        tests++; if (int_force !== 1'b0) begin
            fails++; $display("FAIL force_restart_early: got %b expected 0", int_force); end
        tick();
        tests++; if (int_force !== 1'b1) begin
            fails++; $display("FAIL force_restart_set: got %b expected 1", int_force); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
        tests++; if (int_v !== 1'b0 || int_force !== 1'b0) begin
            fails++; $display("FAIL force_drain: v=%b force=%b expected 0 0", int_v, int_force); end
    endtask

    task automatic test_back_to_back();
        offer(1'b1, 5'd12, 32'hF00D);
        tick();
        offer(1'b0, 5'd8, 32'hA1);
        tick();
        // Enqueue B while consuming A, and consume the float entry in parallel.
        offer(1'b0, 5'd9, 32'hB2);
        int_yumi   = 1'b1;
        float_yumi = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        tick();
        idle_inputs();
        tests++; if (int_v !== 1'b1 || int_rd !== 5'd9 || int_data !== 32'hB2) begin
            fails++; $display("FAIL b2b_head: v=%b rd=%0d data=%h expected 1 9 b2", int_v, int_rd, int_data); end
        tests++; if (float_v !== 1'b0) begin
            fails++; $display("FAIL b2b_float_drained: float_v=%b expected 0", float_v); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
        tests++; if (int_v !== 1'b0) begin
            fails++; $display("FAIL b2b_occupancy: int_v=%b expected 0", int_v); end
    endtask

    task automatic test_illegal_yumi();
        int_yumi = 1'b1;
        repeat (2) tick();
        int_yumi = 1'b0;
        tests++; if (int_v !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL illegal_state: v=%b ready=%b expected 0 1", int_v, in_ready); end
        offer(1'b0, 5'd4, 32'h44);
        tick();
        idle_inputs();
        tests++; if (int_v !== 1'b1 || int_rd !== 5'd4 || int_data !== 32'h44) begin
            fails++; $display("FAIL illegal_enq: v=%b rd=%0d data=%h expected 1 4 44", int_v, int_rd, int_data); end
        int_yumi = 1'b1;
        tick();
        int_yumi = 1'b0;
        tests++; if (int_v !== 1'b0) begin
            fails++; $display("FAIL illegal_drain: v=%b expected 0", int_v); end
    endtask

    task automatic test_async_reset();
        offer(1'b0, 5'd20, 32'h200);
        tick();
        offer(1'b0, 5'd21, 32'h210);
        tick();
        offer(1'b1, 5'd22, 32'h220);
        tick();
        offer(1'b1, 5'd23, 32'h230);
        tick();
        idle_inputs();
        repeat (16) tick();
        tests++; if (int_force !== 1'b1 || float_force !== 1'b1) begin
            fails++; $display("FAIL areset_pre_force: int=%b float=%b expected 1 1", int_force, float_force); end
        #2 reset_n = 1'b0;          // mid-cycle, away from any edge
        #1;
        tests++; if (int_v !== 1'b0 || float_v !== 1'b0 || int_force !== 1'b0 || float_force !== 1'b0) begin
            fails++; $display("FAIL areset_drop: v=%b/%b force=%b/%b expected all 0", int_v, float_v, int_force, float_force); end
        in_float = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin
            fails++; $display("FAIL areset_ready_float: got %b expected 1", in_ready); end
        in_float = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        tests++; if (int_v !== 1'b0 || float_v !== 1'b0) begin
            fails++; $display("FAIL areset_discard: v=%b/%b expected 0 0", int_v, float_v); end
        offer(1'b1, 5'd30, 32'h300);
        tick();
        idle_inputs();
        tests++; if (float_v !== 1'b1 || float_rd !== 5'd30 || float_data !== 32'h300) begin
            fails++; $display("FAIL areset_reuse: v=%b rd=%0d data=%h expected 1 30 300", float_v, float_rd, float_data); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_full();
        test_force();
        test_back_to_back();
        test_illegal_yumi();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vanilla_remote_load_wb_sched.md
VANILLA_REMOTE_LOAD_WB_SCHED -- requirements
Module: vanilla_remote_load_wb_sched

Interface
REQ-001 SHALL have parameter data_width_p, default 32, meaning load response data width.
REQ-002 SHALL have parameter reg_addr_width_p, default 5, meaning destination register id width.
REQ-003 SHALL have parameter fifo_els_p, default 2, meaning per-channel buffer depth; legal values are 2 and greater.
REQ-004 SHALL have parameter stall_threshold_p, default 15, meaning cycles a head response may wait before force.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_v_i, input, 1, a returned remote load response is valid.
REQ-008 SHALL have port in_float_i, input, 1, where 1 targets the float RF and 0 targets the int RF.
REQ-009 SHALL have port in_rd_i, input, reg_addr_width_p, the destination register.
REQ-010 SHALL have port in_data_i, input, data_width_p, the load data.
REQ-011 SHALL have port in_ready_o, output, 1, the response is accepted this cycle when in_v_i is also high.
REQ-012 SHALL have ports int_v_o/int_rd_o/int_data_o/int_force_o, outputs, 1/reg_addr_width_p/data_width_p/1, the int RF writeback request.
REQ-013 SHALL have port int_yumi_i, input, 1, the core consumes the int head.
REQ-014 SHALL have ports float_v_o/float_rd_o/float_data_o/float_force_o, outputs, 1/reg_addr_width_p/data_width_p/1, the float RF writeback request.
REQ-015 SHALL have port float_yumi_i, input, 1, the core consumes the float head.

Function
REQ-016 SHALL keep two independent FIFOs (int, float) of fifo_els_p entries each, holding {rd, data}.
REQ-017 SHALL drive in_ready_o = NOT full(target FIFO selected by in_float_i), combinationally.
REQ-018 SHALL enqueue {in_rd_i, in_data_i} into the target FIFO on the rising edge when in_v_i & in_ready_o.
REQ-019 SHALL give no bypass: a response enqueued into an empty FIFO appears on *_v_o the next cycle (latency 1).
REQ-020 SHALL drive *_v_o = FIFO non-empty, and *_rd_o/*_data_o = the head entry; outputs hold stable while *_v_o is high and no yumi.
REQ-021 SHALL dequeue the head on the rising edge when *_yumi_i is high; *_yumi_i with *_v_o low is illegal and SHALL be ignored (no state change).
REQ-022 SHALL NOT accept an enqueue into a full FIFO even if a dequeue occurs in the same cycle.
REQ-023 SHALL allow a simultaneous enqueue and dequeue on a non-full FIFO; occupancy is unchanged and order is preserved.
REQ-024 SHALL allow a simultaneous int enqueue and float dequeue (or the reverse) independently.
REQ-025 SHALL implement FIFO pointers as wrap-around counters of width clog2(fifo_els_p), with full/empty from an occupancy count of width clog2(fifo_els_p+1).
REQ-026 SHALL keep a per-channel stall counter of width clog2(stall_threshold_p+1) with these rules:
  - 0 when the FIFO is empty;
  - reset to 0 on a yumi, so a new head starts at 0;
  - otherwise incremented each cycle the head is valid and not yumied;
  - saturates at stall_threshold_p.
REQ-027 SHALL drive *_force_o = *_v_o & (stall counter == stall_threshold_p), registered; force stays high until the yumi.
REQ-028 SHALL operate the two channels fully independently, with no cross-channel priority.

Reset
REQ-029 SHALL, while reset_n_i is low (asynchronous assertion), empty both FIFOs, zero pointers and stall counters, and drive *_v_o=0, *_force_o=0.
REQ-030 SHALL drive in_ready_o=1 during and immediately after reset; reset mid-operation discards all buffered responses.
REQ-031 SHALL have reset deassertion take effect at the next rising clk_i; the first enqueue is possible on that edge.

Verification
REQ-032 SHALL cover basic flow: enqueue int rd=3 data=0xDEADBEEF at cycle 0 -> int_v_o=1, rd=3, data=0xDEADBEEF at cycle 1; float_v_o stays 0.
REQ-033 SHALL cover full/backpressure: 2 float enqueues with no yumi -> in_ready_o=0 for in_float_i=1 and 1 for in_float_i=0; a third float offer with a same-cycle yumi is not accepted.
REQ-034 SHALL cover force: hold the int head 15 cycles without yumi -> int_force_o=1 on the 15th cycle after int_v_o rose; after yumi with a second entry queued -> force=0 and the counter restarts.
REQ-035 SHALL cover order/concurrency: enqueue A,B int; on the cycle B enqueues, yumi A -> the head is B next cycle and occupancy is 1.
REQ-036 SHALL cover async reset: assert reset_n_i low between edges with both FIFOs full -> v_o/force_o drop immediately and in_ready_o=1.
REQ-037 SHALL cover illegal yumi: int_yumi_i=1 while int_v_o=0 -> no state change and no underflow.
